lutram_fifo_ctrl: RTL and testbench

//   Valid/ready FIFO controller that drives an external NR1W LUTRAM (1 write port, async read port 0).

---
 rtl/lutram_fifo_ctrl.sv | 76 +++++++
 tb/tb_lutram_fifo_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lutram_fifo_ctrl.sv
// lutram_fifo_ctrl: first-word-fall-through valid/ready FIFO controller driving an external
// 1-write / async-read LUTRAM, with a registered output stage and an empty-FIFO bypass path.
module lutram_fifo_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int ADD_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [CNT_W-1:0] count,
    output logic             ram_wr_en,
    output logic [ADD_W-1:0] ram_wr_add,
    output logic [WIDTH-1:0] ram_wr_data,
    output logic [ADD_W-1:0] ram_rd_add,
    input  logic [WIDTH-1:0] ram_rd_data
);
    localparam logic [ADD_W:0] OCC_FULL = (ADD_W + 1)'(DEPTH);
    logic [ADD_W-1:0] wr_ptr;
    logic [ADD_W-1:0] rd_ptr;
    logic [ADD_W:0]   ram_occ;
    logic [ADD_W:0]   ram_occ_next;
    logic             push;
    logic             pop;
    logic             load;
    logic             ram_rd;
    logic             bypass;
    logic             out_vld_next;

    // in_rdy is built from registered state only, so out_rdy never reaches it combinationally
    assign in_rdy      = !s_rst && (ram_occ != OCC_FULL);
    assign push        = in_vld && in_rdy;
    assign pop         = out_vld && out_rdy;
    assign load        = !out_vld || pop;
    assign ram_rd      = load && (ram_occ != '0);
    assign bypass      = load && (ram_occ == '0) && push;
    assign ram_wr_en   = push && !bypass;
    assign ram_wr_add  = wr_ptr;
    assign ram_wr_data = in_data;
    assign ram_rd_add  = rd_ptr;

    always_comb begin
        out_vld_next = load ? (ram_rd || bypass) : out_vld;
        ram_occ_next = ram_occ + (ADD_W + 1)'(ram_wr_en) - (ADD_W + 1)'(ram_rd);
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_occ  <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            count    <= '0;
        end else begin
            if (ram_wr_en) wr_ptr <= wr_ptr + ADD_W'(1);
            if (ram_rd) rd_ptr <= rd_ptr + ADD_W'(1);
            if (ram_rd) out_data <= ram_rd_data;
            else if (bypass) out_data <= in_data;
            out_vld  <= out_vld_next;
            ram_occ  <= ram_occ_next;
            count    <= CNT_W'(ram_occ_next) + CNT_W'(out_vld_next);
        end
    end

    // an underflow wraps to a large value, so one bound catches both directions
    a_occ_range: assert property (@(posedge clk) disable iff (s_rst) ram_occ_next <= OCC_FULL);
    a_out_stable: assert property (@(posedge clk) disable iff (s_rst)
        out_vld && !out_rdy |=> $stable(out_data));
endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// tb_lutram_fifo_ctrl: directed and random stimulus against lutram_fifo_ctrl with a LUTRAM model;
// a negedge monitor holds a reference queue of accepted words and checks every output each cycle.
module tb_lutram_fifo_ctrl;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int ADD_W = 4;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             s_rst = 1'b1;
    logic             in_vld = 1'b0;
    logic             out_rdy = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_rdy;
    logic             out_vld;
    logic             ram_wr_en;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] ram_wr_data;
    logic [WIDTH-1:0] ram_rd_data;
    logic [CNT_W-1:0] count;
    logic [ADD_W-1:0] ram_wr_add;
    logic [ADD_W-1:0] ram_rd_add;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] q[$];
    int               passed = 0;
    int               total = 0;
    bit               started = 1'b0;

    always #5 clk = ~clk;

    lutram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .s_rst(s_rst),
        .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
        .count(count),
        .ram_wr_en(ram_wr_en), .ram_wr_add(ram_wr_add), .ram_wr_data(ram_wr_data),
        .ram_rd_add(ram_rd_add), .ram_rd_data(ram_rd_data)
    );

    always @(posedge clk) if (ram_wr_en) mem[ram_wr_add] <= ram_wr_data;
    assign ram_rd_data = mem[ram_rd_add];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        started = 1'b1;
    end

    // Reference: the FIFO is a plain queue of every held word; the output shows its head.
    always @(negedge clk) begin
        int  sz;
        int  ram_m;
        bit  p_in;
        bit  p_out;
        bit  w_exp;
        if (started) begin
            sz = q.size();
            ram_m = (sz > 0) ? sz - 1 : 0;
            chk("in_rdy", in_rdy, !s_rst && (sz != DEPTH + 1));
            chk("out_vld", out_vld, sz > 0);
            chk("count", count, sz);
            if (sz > 0) chk("out_data", out_data, q[0]);
            p_in  = !s_rst && in_vld && (sz != DEPTH + 1);
            p_out = !s_rst && (sz > 0) && out_rdy;
            w_exp = p_in && !(ram_m == 0 && (sz == 0 || p_out));
            chk("ram_wr_en", ram_wr_en, w_exp);
            if (w_exp) chk("ram_wr_data", ram_wr_data, in_data);
            if (s_rst) q.delete();
            else begin
                if (p_out) void'(q.pop_front());
                if (p_in) q.push_back(in_data);
            end
        end
    end

    initial begin
        repeat (2) step();
        s_rst = 1'b0;
        #1;
        chk("idle_rdy", in_rdy, 1);
        chk("idle_count", count, 0);
        chk("idle_vld", out_vld, 0);
        repeat (4) step();
        // bypass: empty FIFO, word visible one cycle later without touching the RAM
        in_vld = 1'b1;
        in_data = 32'hA5;
        out_rdy = 1'b1;
        #1;
        chk("byp_wr_en", ram_wr_en, 0);
        step();
        in_vld = 1'b0;
        #1;
        chk("byp_vld", out_vld, 1);
        chk("byp_data", out_data, 32'hA5);
        chk("byp_count", count, 1);
        repeat (3) step();
        // fill with the output stalled: 17 words fit, word 17 is refused
        out_rdy = 1'b0;
        for (int i = 0; i < 18; i++) begin
            in_vld = 1'b1;
            in_data = i;
            if (i == 17) begin
                #1;
                chk("full_rdy", in_rdy, 0);
                chk("full_count", count, DEPTH + 1);
            end
            step();
        end
        in_data = 32'h100;
        out_rdy = 1'b1;
        #1;
        chk("full_pop_rdy", in_rdy, 0);
        step();
        out_rdy = 1'b0;
        #1;
        chk("after_pop_rdy", in_rdy, 1);
        chk("after_pop_count", count, DEPTH);
        step();
        in_vld = 1'b0;
        #1;
        chk("refill_count", count, DEPTH + 1);
        out_rdy = 1'b1;
        repeat (20) step();
        chk("drain_count", count, 0);
        // wrap: three rounds push the pointers well past DEPTH
        for (int r = 0; r < 3; r++) begin
            out_rdy = 1'b0;
            for (int i = 0; i < 12; i++) begin
                in_vld = 1'b1;
                in_data = 32'h1000 * (r + 1) + i;
                step();
            end
            in_vld = 1'b0;
            #1;
            chk("wrap_count_full", count, 12);
            out_rdy = 1'b1;
            repeat (14) step();
            chk("wrap_count_empty", count, 0);
        end
        // random traffic with a reset in the middle of the stream
        for (int n = 0; n < 8000; n++) begin
            step();
            s_rst = (n == 3000);
            in_vld = 1'($urandom_range(0, 1));
            in_data = $urandom;
            out_rdy = 1'($urandom_range(0, 1));
            if (n == 3001) begin
                #1;
                chk("mid_rst_count", count, 0);
                chk("mid_rst_vld", out_vld, 0);
            end
        end
        step();
        s_rst = 1'b0;
        in_vld = 1'b0;
        out_rdy = 1'b1;
        repeat (40) step();
        chk("final_count", count, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
